// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: adds two WIDTH-bit words one bit per clock.
// Each bit is formed by a single full adder outside this block. The sum is
// assembled LSB-first in a shift register, and the result is then held for the
// consumer through a valid/ready handshake.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             last_bit;

  // The counter only reaches WIDTH-1 on the final bit of a word.
  assign last_bit = (count == CW'(WIDTH - 1));

  // Handshake flags come straight from the state, and the adder taps are
  // gated so that the external full adder sees zeros outside RUN.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign fa_a      = (state == RUN) & a_shift[0];
  assign fa_b      = (state == RUN) & b_shift[0];
  assign fa_cin    = (state == RUN) & carry;

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

  // Sequencer state, datapath shift registers and result registers.
  // NOTE: every register here uses non-blocking assignment. Each bit step then
  // reads the pre-edge values of carry, the shift registers and sum_reg, just
  // as the external full adder saw them during the previous cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      a_shift      <= '0;
      b_shift      <= '0;
      carry        <= 1'b0;
      count        <= '0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_shift <= a;
            b_shift <= b;
            carry   <= cin;
            count   <= '0;
            sum_reg <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_shift <= a_shift >> 1;
          b_shift <= b_shift >> 1;
          sum_reg <= {fa_sum, sum_reg[WIDTH-1:1]};
          carry   <= fa_cout;
          count   <= count + CW'(1);
          if (last_bit) begin
            // The carry into the MSB is carry itself, which is the same value
            // that drives fa_cin during RUN.
            cout_reg     <= fa_cout;
            overflow_reg <= carry ^ fa_cout;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Testbench for serial_add_sequencer with WIDTH = 8 and a clock period of 200.
// The external full adder is modelled here. Expected results come from plain
// integer addition of the operands.
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #100 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External 1-bit full adder.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sum, unsigned carry-out and signed overflow from integer addition.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] ms, output logic mco, output logic mov);
    int full;
    int sa, sb, ss;
    full = int'(ma) + int'(mb) + int'(mc);
    ms   = full[W-1:0];
    mco  = full[W];
    sa   = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
    sb   = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
    ss   = sa + sb + int'(mc);
    mov  = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sum"},       32'(sum),       32'd0);
    check({tag, "_cout"},      32'(cout),      32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
    check({tag, "_fa"},        32'({fa_a, fa_b, fa_cin}), 32'd0);
  endtask

  // Runs one transaction, starting and ending at a falling edge. The inputs
  // can be disturbed while RUN and DONE are active, and the bench can hold
  // off the consumer for a number of cycles.
  task automatic run_txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input int hold, input bit noise);
    logic [W-1:0] es;
    logic eco, eov;
    int edges;
    model(ta, tb_, tc, es, eco, eov);
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; out_ready = 1'b0;
    check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges <= 20) begin
      check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      if (noise) begin
        in_valid  = 1'($urandom);
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (!out_valid) edges++;
    end
    out_ready = 1'b0;
    check({tag, "_latency"},  32'(edges),    32'(W));
    check({tag, "_sum"},      32'(sum),      32'(es));
    check({tag, "_cout"},     32'(cout),     32'(eco));
    check({tag, "_overflow"}, 32'(overflow), 32'(eov));
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
      check({tag, "_hold_res"},   32'({cout, overflow, sum}), 32'({eco, eov, es}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_kept_res"},   32'({cout, overflow, sum}), 32'({eco, eov, es}));
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    #50;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_rst");

    run_txn("d3c_05", 8'h3C, 8'h05, 1'b0, 0, 1'b0);
    run_txn("dff_01", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_txn("d7f_01", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run_txn("d80_80", 8'h80, 8'h80, 1'b1, 0, 1'b0);
    run_txn("hold5",  8'hA5, 8'h3B, 1'b1, 5, 1'b1);

    // Reset in the middle of RUN, after 4 bit edges, while cout and overflow
    // still hold 1 from a previous word.
    run_txn("pre_rst", 8'h80, 8'h80, 1'b1, 0, 1'b0);
    in_valid = 1'b1; a = 8'h5A; b = 8'h6B; cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #20 reset_n = 1'b0;
    #10 check_reset_outputs("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    run_txn("d12_34", 8'h12, 8'h34, 1'b0, 0, 1'b0);

    // Random words, some of which have their inputs disturbed.
    for (int i = 0; i < 12; i++)
      run_txn("rand", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // Back-to-back words with in_valid and out_ready held high.
    begin
      logic [W-1:0] qs[$];
      logic         qc[$];
      logic         qo[$];
      int           acc_cyc[$];
      logic [W-1:0] es;
      logic         eco, eov;
      int           results = 0;
      int           n = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      while (results < 3 && n < 60) begin
        if (out_valid) begin
          if (qs.size() == 0) begin
            check("tp_unexpected", 32'd1, 32'd0);
          end else begin
            check("tp_sum",  32'({cout, overflow, sum}), 32'({qc[0], qo[0], qs[0]}));
            void'(qs.pop_front()); void'(qc.pop_front()); void'(qo.pop_front());
          end
          results++;
          if (results == 3) in_valid = 1'b0;
        end
        if (in_ready && in_valid) begin
          model(a, b, cin, es, eco, eov);
          qs.push_back(es); qc.push_back(eco); qo.push_back(eov);
          acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("tp_results", 32'(results), 32'd3);
      check("tp_accepts", 32'(acc_cyc.size()), 32'd3);
      if (acc_cyc.size() == 3) begin
        check("tp_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
        check("tp_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand word offered.
REQ-005 SHALL have port in_ready, output, 1, sequencer can accept an operand word.
REQ-006 SHALL have ports a and b, input, WIDTH each, addends; port cin, input, 1, carry-in.
REQ-007 SHALL have port out_valid, output, 1, result held for consumer.
REQ-008 SHALL have port out_ready, input, 1, consumer takes result.
REQ-009 SHALL have port sum, output, WIDTH, result word.
REQ-010 SHALL have ports cout and overflow, output, 1 each: unsigned carry-out and two's-complement overflow.
REQ-011 SHALL have ports fa_a, fa_b, fa_cin, output, 1 each, driving one external 1-bit full adder.
REQ-012 SHALL have ports fa_sum and fa_cout, input, 1 each, returned from that full adder (combinational path, up to 2 gate delays of 50 each).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept on rising edge with in_valid && in_ready: latch a, b into shift registers, cin into carry register, clear bit counter, clear sum register, go RUN.
REQ-016 SHALL, in RUN, drive fa_a = a_shift[0], fa_b = b_shift[0], fa_cin = carry register; outside RUN drive all three 0.
REQ-017 SHALL, each RUN edge: shift a_shift, b_shift right by 1; shift fa_sum into sum register MSB (LSB-first arrival); load carry register with fa_cout; increment counter.
REQ-018 SHALL, on RUN edge with counter == WIDTH-1, capture overflow = fa_cin XOR fa_cout and cout = fa_cout, and go DONE.
REQ-019 SHALL assert out_valid exactly WIDTH rising edges after the accepting edge.
REQ-020 SHALL hold sum, cout, overflow stable throughout DONE regardless of out_ready.
REQ-021 SHALL leave DONE for IDLE on rising edge with out_ready = 1; sum/cout/overflow keep values until next accept.
REQ-022 SHALL ignore in_valid, a, b, cin while in RUN or DONE (no capture, no state change).
REQ-023 SHALL ignore out_ready outside DONE.
REQ-024 SHALL sustain one transaction per WIDTH+2 cycles when in_valid and out_ready held high.
REQ-025 SHALL wrap result modulo 2^WIDTH; carry beyond bit WIDTH-1 appears only on cout.
REQ-026 SHALL be used with clk period > 100 time units so fa_sum/fa_cout settle before each edge.

Reset
REQ-027 SHALL on reset_n = 0, immediately and independent of clk, force state IDLE, counter 0, carry 0, shift registers 0.
REQ-028 SHALL give reset output values: in_ready 1, out_valid 0, sum 0, cout 0, overflow 0, fa_a/fa_b/fa_cin 0.
REQ-029 SHALL abandon any transaction in progress on reset with no partial result visible, and accept a new word on the first rising edge after reset_n rises.

Verification (WIDTH = 8, clk period 200)
REQ-030 SHALL cover: a=8'h3C, b=8'h05, cin=0 -> sum 8'h41, cout 0, overflow 0; out_valid exactly 8 edges after accept.
REQ-031 SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum 8'h00, cout 1, overflow 0.
REQ-032 SHALL cover: a=8'h7F, b=8'h01, cin=0 -> sum 8'h80, cout 0, overflow 1; then a=8'h80, b=8'h80, cin=1 -> sum 8'h01, cout 1, overflow 1.
REQ-033 SHALL cover: out_ready low 5 cycles in DONE, in_valid toggled with new operands during RUN and DONE -> outputs unchanged, in_ready 0, no second capture; out_ready high -> IDLE next edge.
REQ-034 SHALL cover: reset_n pulsed low mid-RUN (after 4 bit edges) -> outputs at reset values before next clk edge; following 8'h12+8'h34 -> 8'h46, cout 0, overflow 0.
REQ-035 SHALL cover: in_valid and out_ready held high for 3 words -> accepts spaced exactly 10 cycles apart, all results correct.
